// File: rtl/period_meter_pkg.sv
// Shared definitions for the period/duty-cycle meter bank.
// Holds the per-channel FSM encoding, the default counter width and the
// saturation constant for that default width.
package period_meter_pkg;

    // Per-channel measurement state.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StRun   = 2'd2,
        StStall = 2'd3
    } ch_state_e;

    // Default width of the period and high-time counters.
    localparam int unsigned CNT_W_DEF = 16;

    // Saturation value for the default counter width.
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/period_meter_ch.sv
// One period/duty-cycle measurement channel.
// Synchronises sig_i, detects rising edges, counts reference cycles per period
// and per high phase, and latches both on every rise once armed.
// Ports:
//   clk_i     reference clock
//   rst_i     synchronous active-high reset
//   sig_i     asynchronous square wave to measure
//   period_o  latched period in clk_i cycles (saturates at all-ones)
//   high_o    latched high time in clk_i cycles (saturates at all-ones)
//   valid_o   at least one complete measurement is held
//   ovf_o     period counter ran out since the last rise
module period_meter_ch
    import period_meter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    // pcnt one below saturation: the elapsed period (pcnt + 1) has hit CntMax.
    localparam logic [CNT_W-1:0] CntStallAt = {CntMax[CNT_W-1:1], 1'b0};

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic             rise;
    logic [CNT_W-1:0] pcnt_inc;
    logic [CNT_W-1:0] hcnt_inc;

    assign rise     = s2_q & ~s3_q;
    assign pcnt_inc = (pcnt_q == CntMax) ? CntMax : pcnt_q + 1'b1;
    assign hcnt_inc = (hcnt_q == CntMax) ? CntMax : hcnt_q + 1'b1;

    always_comb begin
        s1_d     = sig_i;
        s2_d     = s1_q;
        s3_d     = s2_q;
        state_d  = state_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;

        // Counters run in every state so the first period after arming is
        // already being timed when the arming rise arrives.
        pcnt_d = rise ? '0 : pcnt_inc;
        if (rise) begin
            hcnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (s2_q) begin
            hcnt_d = hcnt_inc;
        end else begin
            hcnt_d = hcnt_q;
        end

        unique case (state_q)
            StIdle: begin
                state_d = StArmed;
            end
            StArmed: begin
                // The arming rise only starts the first period.
                if (rise) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (rise) begin
                    period_d = pcnt_inc;
                    high_d   = hcnt_q;
                    valid_d  = 1'b1;
                    ovf_d    = 1'b0;
                end else if (pcnt_d == CntStallAt) begin
                    state_d = StStall;
                    valid_d = 1'b0;
                    ovf_d   = 1'b1;
                end
            end
            StStall: begin
                if (rise) begin
                    state_d  = StRun;
                    period_d = pcnt_inc;
                    high_d   = hcnt_q;
                    valid_d  = 1'b1;
                    ovf_d    = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            state_q  <= StIdle;
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign period_o = period_q;
    assign high_o   = high_q;
    assign valid_o  = valid_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/multi_period_meter.sv
// Bank of NB_CH independent period/duty-cycle meters with a registered read port.
// Ports:
//   ClkIn     reference clock
//   Reset     synchronous active-high reset
//   SigIn     signals to measure, asynchronous to ClkIn
//   RdReq     read request, sampled every cycle
//   RdChan    channel to read, sampled with RdReq
//   RdAck     read data valid, one cycle after RdReq
//   RdPeriod  latched period of the selected channel
//   RdHigh    latched high time of the selected channel
//   RdValid   selected channel holds a complete measurement
//   RdOvf     selected channel's period counter saturated
// Read data holds its last value while RdAck is low.
module multi_period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned NB_CH = 24,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned CH_W  = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic             ClkIn,
    input  logic             Reset,
    input  logic [NB_CH-1:0] SigIn,
    input  logic             RdReq,
    input  logic [CH_W-1:0]  RdChan,
    output logic             RdAck,
    output logic [CNT_W-1:0] RdPeriod,
    output logic [CNT_W-1:0] RdHigh,
    output logic             RdValid,
    output logic             RdOvf
);

    logic [CNT_W-1:0] ch_period [NB_CH];
    logic [CNT_W-1:0] ch_high   [NB_CH];
    logic [NB_CH-1:0] ch_valid;
    logic [NB_CH-1:0] ch_ovf;

    for (genvar g = 0; g < NB_CH; g++) begin : gen_ch
        period_meter_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i    (ClkIn),
            .rst_i    (Reset),
            .sig_i    (SigIn[g]),
            .period_o (ch_period[g]),
            .high_o   (ch_high[g]),
            .valid_o  (ch_valid[g]),
            .ovf_o    (ch_ovf[g])
        );
    end

    logic [CNT_W-1:0] sel_period;
    logic [CNT_W-1:0] sel_high;
    logic             sel_valid;
    logic             sel_ovf;

    logic             rd_ack_q, rd_ack_d;
    logic [CNT_W-1:0] rd_period_q, rd_period_d;
    logic [CNT_W-1:0] rd_high_q, rd_high_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_ovf_q, rd_ovf_d;

    // Out-of-range channel numbers match nothing and read back as zeros.
    always_comb begin
        sel_period = '0;
        sel_high   = '0;
        sel_valid  = 1'b0;
        sel_ovf    = 1'b0;
        for (int i = 0; i < NB_CH; i++) begin
            if (RdChan == CH_W'(i)) begin
                sel_period = ch_period[i];
                sel_high   = ch_high[i];
                sel_valid  = ch_valid[i];
                sel_ovf    = ch_ovf[i];
            end
        end
    end

    always_comb begin
        rd_ack_d    = RdReq;
        rd_period_d = rd_period_q;
        rd_high_d   = rd_high_q;
        rd_valid_d  = rd_valid_q;
        rd_ovf_d    = rd_ovf_q;
        if (RdReq) begin
            rd_period_d = sel_period;
            rd_high_d   = sel_high;
            rd_valid_d  = sel_valid;
            rd_ovf_d    = sel_ovf;
        end
    end

    always_ff @(posedge ClkIn) begin
        if (Reset) begin
            rd_ack_q    <= 1'b0;
            rd_period_q <= '0;
            rd_high_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_ovf_q    <= 1'b0;
        end else begin
            rd_ack_q    <= rd_ack_d;
            rd_period_q <= rd_period_d;
            rd_high_q   <= rd_high_d;
            rd_valid_q  <= rd_valid_d;
            rd_ovf_q    <= rd_ovf_d;
        end
    end

    assign RdAck    = rd_ack_q;
    assign RdPeriod = rd_period_q;
    assign RdHigh   = rd_high_q;
    assign RdValid  = rd_valid_q;
    assign RdOvf    = rd_ovf_q;

endmodule

// File: tb/tb_multi_period_meter.sv
// Directed bench for multi_period_meter with 24 channels and 8-bit counters.
module tb_multi_period_meter;

    localparam int unsigned NB_CH = 24;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned CH_W  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NB_CH-1:0] sig;
    logic             rd_req;
    logic [CH_W-1:0]  rd_chan;
    logic             rd_ack;
    logic [CNT_W-1:0] rd_period;
    logic [CNT_W-1:0] rd_high;
    logic             rd_valid;
    logic             rd_ovf;

    always #5 clk = ~clk;

    multi_period_meter #(
        .NB_CH (NB_CH),
        .CNT_W (CNT_W),
        .CH_W  (CH_W)
    ) dut (
        .ClkIn    (clk),
        .Reset    (rst),
        .SigIn    (sig),
        .RdReq    (rd_req),
        .RdChan   (rd_chan),
        .RdAck    (rd_ack),
        .RdPeriod (rd_period),
        .RdHigh   (rd_high),
        .RdValid  (rd_valid),
        .RdOvf    (rd_ovf)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Per-channel divider-style generators; per_cfg == 0 means manual drive.
    int               per_cfg [NB_CH];
    int               hi_cfg  [NB_CH];
    int               phase   [NB_CH];
    logic [NB_CH-1:0] man_sig;

    typedef struct {
        int ch;
        int per;
        int hi;
        int val;
        int ovf;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NB_CH; i++) begin
            if (per_cfg[i] != 0) begin
                sig[i]   = (phase[i] < hi_cfg[i]);
                phase[i] = (phase[i] + 1) % per_cfg[i];
            end else begin
                sig[i] = man_sig[i];
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_man(input int ch, input logic v);
        man_sig[ch] = v;
        sig[ch]     = v;
    endtask

    task automatic read_chk(input string name, input int ch, input int per, input int hi,
                            input int val, input int ovf);
        rd_chan = CH_W'(ch);
        rd_req  = 1'b1;
        step();
        rd_req  = 1'b0;
        check({name, " ack"}, int'(rd_ack), 1);
        check({name, " period"}, int'(rd_period), per);
        check({name, " high"}, int'(rd_high), hi);
        check({name, " valid"}, int'(rd_valid), val);
        check({name, " ovf"}, int'(rd_ovf), ovf);
    endtask

    initial begin
        tbl[0] = '{ch: 0,  per: 48,  hi: 24, val: 1, ovf: 0};
        tbl[1] = '{ch: 1,  per: 10,  hi: 3,  val: 1, ovf: 0};
        tbl[2] = '{ch: 7,  per: 2,   hi: 1,  val: 1, ovf: 0};
        tbl[3] = '{ch: 12, per: 100, hi: 99, val: 1, ovf: 0};
        tbl[4] = '{ch: 23, per: 200, hi: 1,  val: 1, ovf: 0};
        tbl[5] = '{ch: 4,  per: 0,   hi: 0,  val: 0, ovf: 0};
        tbl[6] = '{ch: 30, per: 0,   hi: 0,  val: 0, ovf: 0};

        for (int i = 0; i < NB_CH; i++) begin
            per_cfg[i] = 0;
            hi_cfg[i]  = 0;
            phase[i]   = 0;
        end
        man_sig = '0;
        sig     = '0;
        rd_req  = 1'b0;
        rd_chan = '0;
        rst     = 1'b1;

        // Reset state
        steps(3);
        check("reset ack", int'(rd_ack), 0);
        check("reset period", int'(rd_period), 0);
        check("reset high", int'(rd_high), 0);
        check("reset valid", int'(rd_valid), 0);
        check("reset ovf", int'(rd_ovf), 0);
        rst = 1'b0;
        steps(2);
        read_chk("post-reset ch0", 0, 0, 0, 0, 0);

        // Several channels running concurrently, read back from a table
        for (int i = 0; i < 5; i++) begin
            per_cfg[tbl[i].ch] = tbl[i].per;
            hi_cfg[tbl[i].ch]  = tbl[i].hi;
            phase[tbl[i].ch]   = 0;
        end
        steps(700);
        for (int i = 0; i < 7; i++) begin
            read_chk($sformatf("table ch%0d", tbl[i].ch), tbl[i].ch, tbl[i].per, tbl[i].hi,
                     tbl[i].val, tbl[i].ovf);
        end
        for (int i = 0; i < NB_CH; i++) per_cfg[i] = 0;
        man_sig = '0;
        sig     = '0;

        // Arming rise latches nothing; the next rise 10 cycles later does
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        steps(2);
        set_man(5, 1'b1);
        steps(4);
        set_man(5, 1'b0);
        steps(2);
        read_chk("ch5 armed", 5, 0, 0, 0, 0);
        steps(3);
        set_man(5, 1'b1);
        steps(5);
        read_chk("ch5 first", 5, 10, 4, 1, 0);

        // Stall after a held-high input, then recover
        set_man(3, 1'b1);
        steps(5);
        set_man(3, 1'b0);
        steps(5);
        set_man(3, 1'b1);
        steps(256);
        read_chk("ch3 pre-stall", 3, 10, 5, 1, 0);
        read_chk("ch3 stall", 3, 10, 5, 0, 1);
        set_man(3, 1'b0);
        steps(10);
        set_man(3, 1'b1);
        steps(5);
        read_chk("ch3 saturated", 3, 255, 255, 1, 0);
        steps(4);
        set_man(3, 1'b0);
        steps(10);
        set_man(3, 1'b1);
        steps(5);
        read_chk("ch3 recovered", 3, 20, 10, 1, 0);

        // Read in the same cycle as a latch update sees the old value
        set_man(2, 1'b1);
        steps(24);
        set_man(2, 1'b0);
        steps(24);
        set_man(2, 1'b1);
        steps(24);
        set_man(2, 1'b0);
        steps(26);
        set_man(2, 1'b1);
        steps(2);
        read_chk("ch2 same-cycle", 2, 48, 24, 1, 0);
        read_chk("ch2 next", 2, 50, 24, 1, 0);
        step();
        check("hold ack", int'(rd_ack), 0);
        check("hold period", int'(rd_period), 50);

        // Back-to-back reads including an out-of-range channel
        rd_req  = 1'b1;
        rd_chan = CH_W'(0);
        step();
        check("b2b0 ack", int'(rd_ack), 1);
        check("b2b0 valid", int'(rd_valid), 0);
        rd_chan = CH_W'(1);
        step();
        check("b2b1 ack", int'(rd_ack), 1);
        check("b2b1 period", int'(rd_period), 0);
        rd_chan = CH_W'(2);
        step();
        check("b2b2 ack", int'(rd_ack), 1);
        check("b2b2 period", int'(rd_period), 50);
        check("b2b2 valid", int'(rd_valid), 1);
        rd_chan = CH_W'(30);
        step();
        check("b2b30 ack", int'(rd_ack), 1);
        check("b2b30 period", int'(rd_period), 0);
        check("b2b30 high", int'(rd_high), 0);
        check("b2b30 valid", int'(rd_valid), 0);
        check("b2b30 ovf", int'(rd_ovf), 0);
        rd_req = 1'b0;
        step();
        check("b2b end ack", int'(rd_ack), 0);

        // Reset in the middle of a measurement while a read is requested
        per_cfg[0] = 48;
        hi_cfg[0]  = 24;
        phase[0]   = 0;
        steps(100);
        rd_req  = 1'b1;
        rd_chan = CH_W'(2);
        step();
        check("pre-rst ack", int'(rd_ack), 1);
        check("pre-rst period", int'(rd_period), 50);
        rst        = 1'b1;
        per_cfg[0] = 0;
        set_man(0, 1'b0);
        step();
        check("rst-read ack", int'(rd_ack), 0);
        check("rst-read period", int'(rd_period), 0);
        rst    = 1'b0;
        rd_req = 1'b0;
        steps(2);
        set_man(0, 1'b1);
        steps(10);
        read_chk("ch0 one rise", 0, 0, 0, 0, 0);
        set_man(0, 1'b0);
        steps(10);
        set_man(0, 1'b1);
        steps(5);
        read_chk("ch0 two rises", 0, 21, 11, 1, 0);
        read_chk("ch2 after rst", 2, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_period_meter.md
# multi_period_meter

Bank of NB_CH independent period/duty-cycle meters, the measuring counterpart of the multi-channel frequency divider bank. Each channel synchronises one input square wave, counts ClkIn cycles per period and per high phase, and latches both on every rising edge. A one-cycle registered read port returns any channel's latest measurement, so software or a checker can confirm divider settings such as period 48 / high 24.

## Interface
- NB_CH, 24, number of measured channels
- CNT_W, 16, width of period and high-time counters
- CH_W, $clog2(NB_CH), width of channel select (derived)
- ClkIn  in  1  reference clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- SigIn  in  NB_CH  signals to measure, treated as asynchronous to ClkIn
- RdReq  in  1  read request, sampled every cycle
- RdChan  in  CH_W  channel to read, sampled with RdReq
- RdAck  out  1  read data valid, one cycle after RdReq
- RdPeriod  out  CNT_W  latched period in ClkIn cycles
- RdHigh  out  CNT_W  latched high time in ClkIn cycles
- RdValid  out  1  channel holds at least one complete measurement
- RdOvf  out  1  period counter saturated (signal slow or stopped)

## Operation
- Per channel: 2-flop synchroniser (s1, s2), then a third flop s3; rising edge rise = s2 & ~s3.
- Channel FSM: IDLE -> ARMED on Reset release; ARMED -> RUN on first rise; RUN stays RUN on every rise; RUN -> STALL when period counter reaches 2^CNT_W-1; STALL -> RUN on next rise.
- Period counter pcnt: on rise, pcnt <= 0; otherwise pcnt <= pcnt+1, saturating at all-ones.
- High counter hcnt: on rise, hcnt <= 1; else if s2 = 1, hcnt <= hcnt+1, saturating; else hold.
- Latch on rise in RUN or STALL: period <= pcnt+1, saturated to all-ones; high <= hcnt; valid <= 1; ovf <= 0. A rise in ARMED latches nothing and only enters RUN.
- Entering STALL: valid <= 0, ovf <= 1; the latched period and high values hold.
- Read: if RdReq = 1, the next cycle drives RdAck = 1 with the selected channel's period, high, valid and ovf. These are the register values from the RdReq cycle, so a latch in that same cycle is not visible. Back-to-back RdReq gives RdAck every cycle.
- RdChan >= NB_CH: RdAck = 1 with all data outputs 0.
- Reading has no side effects on channel state.

## Timing
- Reset (synchronous, 1 cycle minimum):
  - All channels go to IDLE, then ARMED on the first cycle after Reset.
  - Counters, latches, valid, ovf and synchronisers are cleared to 0.
  - RdAck, RdPeriod, RdHigh, RdValid, RdOvf are 0.
- Reset during a read: RdAck is 0 in the following cycle.
- Input to edge latency: 3 ClkIn cycles from a SigIn transition to rise (2 sync + 1 detect). Latched values update in the cycle after rise.
- Read latency: exactly 1 cycle from RdReq to RdAck and data; no stalls.
- Outputs hold their last read values while RdAck = 0.
- Measurable period range: 2 .. 2^CNT_W-2 cycles. A period of 2^CNT_W-1 or more enters STALL.
- SigIn constant 1 or 0: channel reaches STALL after 2^CNT_W-1 cycles from the last rise.
- Pulses shorter than one ClkIn cycle may be missed; this is not an error condition.

## Structure
- Shared package (period_meter_pkg) holds:
  - channel FSM enum: IDLE, ARMED, RUN, STALL
  - default CNT_W
  - saturation constant CNT_MAX = {CNT_W{1'b1}}
- Sub-module period_meter_ch holds one channel: synchroniser, edge detect, FSM, counters and latches. Its outputs are period, high, valid and ovf.
- Top level instantiates NB_CH copies of period_meter_ch in a generate loop and implements the registered read mux.

## Test plan
- Divider-style input, period 48 / high 24 on channel 0, at least 3 periods, then read channel 0 -> RdPeriod = 48, RdHigh = 24, RdValid = 1, RdOvf = 0.
- Reset release, single rise on channel 5, then read channel 5 -> RdValid = 0, RdPeriod = 0. After a second rise 10 cycles later -> RdPeriod = 10.
- Channel 3 held high after one valid measurement, CNT_W = 8 -> after 255 cycles read gives RdValid = 0, RdOvf = 1, old values held. Next rise 20 cycles later: first latch is 255 (saturated), following latch is 20 with RdOvf = 0.
- RdReq on channel 2 in the same cycle its latch updates from 48 to 50 -> RdAck returns 48. An immediate second RdReq returns 50.
- RdReq held for 4 cycles with RdChan = 0, 1, 2, 30 (NB_CH = 24) -> RdAck high for 4 consecutive cycles; the fourth returns all zeros.
- Reset asserted mid-measurement with RdReq active -> next cycle RdAck = 0. All channels report valid = 0 until two new rises occur.
